// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the CPU front end.
//   RESET_PC_DEFAULT - default first fetch address after reset
//   INST_W           - instruction width in bits
//   fetch_entry_t    - one buffered fetch result {pc, inst, fault}
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_W           = 32;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO with flush.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush           - empty the FIFO this cycle (overrides push and pop)
//   push, push_data - write one entry
//   pop             - consume the head entry
//   head_data       - head entry, all zeros while empty
//   count           - number of valid entries (0..2)
module fetch_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count_q != 2'd0) ? mem[rd_ptr] : '0;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && count_q == 2'd2));
            assert (!(pop && count_q == 2'd0));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, drives the code memory
// byte address, absorbs the memory's one-cycle read latency and hands
// {pc, inst, fault} to decode through a 2-entry valid/ready buffer.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   redirect, redirect_pc    - branch taken and its target (byte address)
//   imem_addr                - byte address to code memory (= pc_q)
//   imem_inst                - memory data for the address of last cycle
//   out_valid, out_ready     - decode handshake
//   out_inst, out_pc         - head instruction and its byte address
//   out_fault                - head was fetched from an out-of-range address
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          CODE_SIZE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc,
    output logic              out_fault
);

    localparam logic [32:0] CODE_LIMIT = 33'(CODE_SIZE);

    logic [31:0]  pc_q;
    logic         req_valid_q;
    logic [31:0]  req_pc_q;
    logic         req_fault_q;

    logic [1:0]   count;
    logic         pop;
    logic         push;
    logic         issue;
    logic [2:0]   occupancy;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign imem_addr = pc_q;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    // Slots committed after this edge: buffered + in flight - leaving.
    // Issuing only below 2 guarantees every response finds a free slot.
    assign occupancy = {1'b0, count} + {2'b00, req_valid_q} - {2'b00, pop};
    assign issue     = (occupancy < 3'd2);

    assign push = req_valid_q && !redirect;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = req_pc_q;
        push_entry.inst  = req_fault_q ? '0 : imem_inst;
        push_entry.fault = req_fault_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            req_fault_q <= 1'b0;
        end else if (redirect) begin
            pc_q        <= redirect_pc & ~32'h3;
            req_valid_q <= 1'b0;
        end else if (issue) begin
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
            req_fault_q <= ({1'b0, pc_q} >= CODE_LIMIT);
            pc_q        <= pc_q + 32'd4;
        end else begin
            req_valid_q <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign out_inst  = head_entry.inst;
    assign out_pc    = head_entry.pc;
    assign out_fault = head_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .CODE_SIZE (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_fault   (out_fault)
    );

    // Code memory: word k holds A000_0000 + k; out of range reads garbage
    // so that zeroing of faulting fetches is visible.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'd1024) return 32'hA000_0000 + (addr >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) imem_inst <= mem_word(imem_addr);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
        n_checks++; if (out_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", out_fault); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        reset = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lat1_valid: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_lat2_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_first_pc: got %h expected 0", out_pc); end
        n_checks++; if (out_inst !== 32'hA000_0000) begin n_fail++; $display("FAIL reset_first_inst: got %h expected a0000000", out_inst); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (out_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, 32'(4 * i)); end
            n_checks++; if (out_inst !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, out_inst, 32'hA000_0000 + 32'(i)); end
            tick();
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        tick();
        // Head is pc 12, pc 16 in flight, imem_addr 20.
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_checks++; if (out_pc !== 32'd12 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_head[%0d]: got valid %b pc %h expected valid 1 pc 0000000c", s, out_valid, out_pc); end
            n_checks++; if (out_inst !== 32'hA000_0003) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h expected a0000003", s, out_inst); end
            n_checks++; if (imem_addr !== 32'd20) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 00000014", s, imem_addr); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(16 + 4 * i)) begin n_fail++; $display("FAIL stall_resume[%0d]: got valid %b pc %h expected valid 1 pc %h", i, out_valid, out_pc, 32'(16 + 4 * i)); end
            n_checks++; if (out_inst !== 32'hA000_0004 + 32'(i)) begin n_fail++; $display("FAIL stall_resume_inst[%0d]: got %h expected %h", i, out_inst, 32'hA000_0004 + 32'(i)); end
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_valid: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_e1_valid: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_fail++; $display("FAIL redir_target: got valid %b pc %h expected valid 1 pc 00000040", out_valid, out_pc); end
        n_checks++; if (out_inst !== 32'hA000_0010) begin n_fail++; $display("FAIL redir_target_inst: got %h expected a0000010", out_inst); end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * i)) begin n_fail++; $display("FAIL redir_follow[%0d]: got valid %b pc %h expected valid 1 pc %h", i, out_valid, out_pc, 32'h40 + 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_pop();
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        // Head pc 8 is accepted by decode on the same edge as the redirect.
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin n_fail++; $display("FAIL rpop_head: got valid %b pc %h expected valid 1 pc 00000008", out_valid, out_pc); end
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_e0_valid: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_e1_valid: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin n_fail++; $display("FAIL rpop_target: got valid %b pc %h expected valid 1 pc 00000080", out_valid, out_pc); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h84) begin n_fail++; $display("FAIL rpop_next: got valid %b pc %h expected valid 1 pc 00000084", out_valid, out_pc); end
    endtask

    task automatic test_fault();
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h3FE;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3FC) begin n_fail++; $display("FAIL fault_last_pc: got valid %b pc %h expected valid 1 pc 000003fc", out_valid, out_pc); end
        n_checks++; if (out_fault !== 1'b0 || out_inst !== 32'hA000_00FF) begin n_fail++; $display("FAIL fault_last_data: got fault %b inst %h expected fault 0 inst a00000ff", out_fault, out_inst); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin n_fail++; $display("FAIL fault_oob_pc: got valid %b pc %h expected valid 1 pc 00000400", out_valid, out_pc); end
        n_checks++; if (out_fault !== 1'b1 || out_inst !== 32'h0) begin n_fail++; $display("FAIL fault_oob_data: got fault %b inst %h expected fault 1 inst 00000000", out_fault, out_inst); end
        tick();
        n_checks++; if (out_pc !== 32'h404 || out_fault !== 1'b1) begin n_fail++; $display("FAIL fault_oob_next: got pc %h fault %b expected pc 00000404 fault 1", out_pc, out_fault); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (imem_addr === 32'h0) begin n_fail++; $display("FAIL rfull_pre_addr: got %h expected nonzero", imem_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_valid: got %b expected 0", out_valid); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rfull_addr: got %h expected 0", imem_addr); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_lat1: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL rfull_lat2: got valid %b pc %h expected valid 1 pc 0", out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_fault();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
